// File: rtl/stream_accumulator.sv
// Per-lane accumulator: sums NP input beats of NC signed lanes and emits one beat of exact-width sums.
// Optional STREAM_ACCUMULATOR_OVERLAP_EN lets a new group start on the same cycle the held sum is taken.
//
// state | meaning
// ACC   | accepting beats, building the per-lane sums
// HOLD  | sum presented downstream, waiting for the output transfer
module stream_accumulator #(
  parameter  int NP = 5,
  parameter  int NC = 6,
  parameter  int WV = 4,
  localparam int WA = $clog2(NP) + 1 + WV
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iValid_AS,
  output logic               oReady_AS,
  input  logic [NC*(WV+1)-1:0] iData_AS,
  output logic               oValid_BM,
  input  logic               iReady_BM,
  output logic [NC*WA-1:0]   oData_BM
);

  localparam int             CW   = (NP > 1) ? $clog2(NP) : 1;
  localparam logic [CW-1:0]  LAST = CW'(NP - 1);

  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic signed [WA-1:0]  acc_q [NC];
  logic signed [WA-1:0]  acc_d [NC];
  logic signed [WA-1:0]  lane_ext [NC];
  logic signed [WV:0]    lane_raw [NC];
  logic                  in_xfer, out_xfer;

  always_comb begin
    for (int i = 0; i < NC; i++) begin
      lane_raw[i] = iData_AS[i*(WV+1) +: WV+1];
      lane_ext[i] = WA'(lane_raw[i]);
    end
  end

  assign in_xfer  = iValid_AS & oReady_AS;
  assign out_xfer = oValid_BM & iReady_BM;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= ACC;
      cnt_q   <= '0;
      for (int i = 0; i < NC; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < NC; i++) acc_q[i] <= acc_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < NC; i++) acc_d[i] = acc_q[i];
    case (state_q)
      ACC: begin
        if (in_xfer) begin
          for (int i = 0; i < NC; i++)
            acc_d[i] = (cnt_q == '0) ? lane_ext[i] : acc_q[i] + lane_ext[i];
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_xfer) begin
          state_d = ACC;
`ifdef STREAM_ACCUMULATOR_OVERLAP_EN
          // first beat of the next group lands on the same edge the sum leaves
          if (in_xfer) begin
            for (int i = 0; i < NC; i++) acc_d[i] = lane_ext[i];
            if (LAST == '0) begin
              cnt_d   = '0;
              state_d = HOLD;
            end else begin
              cnt_d = CW'(1);
            end
          end
`endif
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_comb begin
    oValid_BM = (state_q == HOLD);
`ifdef STREAM_ACCUMULATOR_OVERLAP_EN
    oReady_AS = (state_q == ACC) | iReady_BM;
`else
    oReady_AS = (state_q == ACC);
`endif
    for (int i = 0; i < NC; i++) oData_BM[i*WA +: WA] = acc_q[i];
  end

endmodule

// File: doc/stream_accumulator.md
Name: stream_accumulator

Overview:
- Sits directly upstream of the delta stage and produces its first operand stream (Accum1).
- Accepts NP consecutive valid/ready beats. Each beat carries NC signed lane values, WV+1 bits each.
- Sums the beats per lane and emits one beat of NC signed sums, clog2(NP)+1+WV bits each, via valid/ready.
- Sum width is exact for NP terms, so no saturation is needed here; saturation happens downstream.

Parameters:
- NP, 5, number of beats summed per output (≥1)
- NC, 6, number of parallel lanes
- WV, 4, value width; input lanes are WV+1 bits signed

Ports:
- iCLK  in  1  clock; all state changes on the rising edge
- iRST  in  1  synchronous active-high reset
- iValid_AS  in  1  input beat valid
- oReady_AS  out  1  input beat ready
- iData_AS  in  NC*(WV+1)  lane i at [i*(WV+1) +: WV+1], signed
- oValid_BM  out  1  sum valid
- iReady_BM  in  1  sum ready
- oData_BM  out  NC*WA  lane i at [i*WA +: WA], signed, where WA = clog2(NP)+1+WV

Behaviour:
- Clock and reset: one clock, iCLK. Reset iRST is synchronous, active-high, sampled on the iCLK rising edge.
- Reset values:
  - state = ACC, count = 0, all accumulators = 0.
  - oValid_BM = 0, oData_BM = 0, oReady_AS = 1 from the first cycle after reset.
- Reset mid-operation: any partial sum or held output is discarded. No beat is emitted for a partial group.
- Transfers: an input transfer occurs when iValid_AS & oReady_AS. An output transfer occurs when oValid_BM & iReady_BM.
- Counter width is max(1, clog2(NP)).
- State ACC:
  - oReady_AS = 1, oValid_BM = 0.
  - On an input transfer with count = 0: acc[i] = sign-extend(lane i).
  - On an input transfer with count > 0: acc[i] = acc[i] + sign-extend(lane i).
  - If count = NP-1 on that transfer: count → 0, state → HOLD. Otherwise count increments.
  - No input transfer: nothing changes.
- State HOLD:
  - oValid_BM = 1, oReady_AS = 0.
  - oData_BM = acc, held stable until the output transfer.
  - On the output transfer: state → ACC.
- Latency: oValid_BM rises in the cycle after the NP-th input transfer. Throughput is one output per NP+1 cycles minimum.
- Valid handling: oValid_BM never depends combinationally on iReady_BM. oReady_AS depends only on state (default build).
- Arithmetic: two's-complement throughout, no overflow possible.
  - Bound: NP·2^WV ≤ 2^(WA-1).
- NP = 1: every accepted beat goes straight to HOLD. Output equals the sign-extended input.
- iValid_AS is ignored in HOLD; the upstream must hold its data until ready.
- Output register is the accumulator itself; no separate output skid buffer.

Optional Feature:
- Macro: STREAM_ACCUMULATOR_OVERLAP_EN.
- Defined:
  - In HOLD, oReady_AS = iReady_BM (combinational path).
  - An input transfer coincident with the output transfer loads acc[i] = sign-extend(lane i).
  - count becomes 1. State → ACC, or stays HOLD if NP = 1.
  - Removes the bubble cycle: sustained throughput is one output per NP cycles.
- Undefined: behaviour exactly as above, with oReady_AS = 0 throughout HOLD.

Test Plan:
- Full-scale positive (NP=5, NC=6, WV=4): five beats with every lane = 15, iReady_BM=1 → oValid_BM rises the cycle after beat 5; every lane = 75 (8'h4B). Output accepted immediately, then oReady_AS=1.
- Full-scale negative: five beats with every lane = -16 → every lane = -80 (8'hB0). Mixed lane test: lane k gets value k-3 on all beats → lane k = 5·(k-3).
- Backpressure: sum ready, iReady_BM held 0 for 3 cycles with iValid_AS=1 → oData_BM stable, oReady_AS=0 (default build), no beats consumed. Transfer happens on the 4th cycle.
- Reset mid-group: three beats of 7, then iRST for 1 cycle, then five beats of 1 → single output of 5 per lane. No output is produced for the aborted group.
- NP=1 build: beats 3, -2, 15 streamed with iReady_BM=1 → outputs 3, -2, 15, one every 2 cycles.
- With STREAM_ACCUMULATOR_OVERLAP_EN: continuous iValid_AS with all lanes = 2, iReady_BM=1 → outputs of 10 every 5 cycles, no idle input cycle. Without the macro, outputs come every 6 cycles.
